// File: rtl/bomb_pkg.sv
// Shared tile encodings and enums for the bomb controller.
// Tile codes match drawcon and the map init files.
package bomb_pkg;

    localparam int unsigned T_EMPTY     = 0;
    localparam int unsigned T_WALL      = 1;
    localparam int unsigned T_BRICK     = 2;
    localparam int unsigned T_BOMB      = 3;
    localparam int unsigned T_EXPLOSION = 4;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ARMED,
        BLAST_WALK,
        BLAST_HOLD,
        CLEAR_WALK
    } state_e;

    typedef enum logic {
        M_BLAST,
        M_CLEAR
    } mode_e;

endpackage

// File: rtl/tile_walker.sv
// Walks the blast cross around a center tile: direction/step state,
// bounds check, target address and per-tile verdict for either pass.
module tile_walker
    import bomb_pkg::*;
#(
    parameter int NUM_ROW    = 11,
    parameter int NUM_COL    = 19,
    parameter int DATA_WIDTH = 4,
    parameter int RANGE      = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               adv,
    input  logic                               next_dir,
    input  mode_e                              mode,
    input  logic [$clog2(NUM_ROW)-1:0]         row,
    input  logic [$clog2(NUM_COL)-1:0]         col,
    input  logic [DATA_WIDTH-1:0]              rd_data,
    output logic [$clog2(NUM_ROW*NUM_COL)-1:0] addr,
    output logic                               in_bounds,
    output logic                               last_k,
    output logic                               last_dir,
    output logic                               do_write,
    output logic [DATA_WIDTH-1:0]              wr_val,
    output logic                               cont
);

    localparam int AW = $clog2(NUM_ROW*NUM_COL);
    localparam int KW = $clog2(RANGE+1);

    dir_e          dir_q, dir_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] r_w, c_w, k_w, tr, tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= UP;
            k_q   <= '0;
        end else begin
            dir_q <= dir_d;
            k_q   <= k_d;
        end
    end

    always_comb begin
        dir_d = dir_q;
        k_d   = k_q;
        if (start) begin
            dir_d = UP;
            k_d   = KW'(1);
        end else if (next_dir) begin
            dir_d = dir_e'(dir_q + 2'd1);
            k_d   = KW'(1);
        end else if (adv) begin
            k_d = k_q + KW'(1);
        end
    end

    always_comb begin
        r_w       = AW'(row);
        c_w       = AW'(col);
        k_w       = AW'(k_q);
        tr        = r_w;
        tc        = c_w;
        in_bounds = 1'b0;
        unique case (dir_q)
            UP: begin
                in_bounds = r_w >= k_w;
                tr        = r_w - k_w;
            end
            DOWN: begin
                in_bounds = (r_w + k_w) <= AW'(NUM_ROW-1);
                tr        = r_w + k_w;
            end
            LEFT: begin
                in_bounds = c_w >= k_w;
                tc        = c_w - k_w;
            end
            RIGHT: begin
                in_bounds = (c_w + k_w) <= AW'(NUM_COL-1);
                tc        = c_w + k_w;
            end
            default: in_bounds = 1'b0;
        endcase
        addr     = tr * AW'(NUM_COL) + tc;
        last_k   = (k_q == KW'(RANGE));
        last_dir = (dir_q == RIGHT);
    end

    // Blast: empty burns on, brick burns and stops. Clear: undo explosions.
    always_comb begin
        do_write = 1'b0;
        wr_val   = '0;
        cont     = 1'b0;
        if (mode == M_BLAST) begin
            if (rd_data == DATA_WIDTH'(T_EMPTY)) begin
                do_write = 1'b1;
                wr_val   = DATA_WIDTH'(T_EXPLOSION);
                cont     = 1'b1;
            end else if (rd_data == DATA_WIDTH'(T_BRICK)) begin
                do_write = 1'b1;
                wr_val   = DATA_WIDTH'(T_EXPLOSION);
            end
        end else if (rd_data == DATA_WIDTH'(T_EXPLOSION)) begin
            do_write = 1'b1;
            wr_val   = DATA_WIDTH'(T_EMPTY);
            cont     = 1'b1;
        end
    end

endmodule

// File: rtl/bomb_ctrl.sv
// Bomb placement, fuse, blast walk, hold and clear; a write-side
// client of map_mem with its own synchronous read port.
module bomb_ctrl
    import bomb_pkg::*;
#(
    parameter int NUM_ROW     = 11,
    parameter int NUM_COL     = 19,
    parameter int DATA_WIDTH  = 4,
    parameter int FUSE_TICKS  = 120,
    parameter int BLAST_TICKS = 30,
    parameter int RANGE       = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick,
    input  logic                               place_req,
    input  logic [$clog2(NUM_ROW)-1:0]         place_row,
    input  logic [$clog2(NUM_COL)-1:0]         place_col,
    output logic                               place_ack,
    output logic                               busy,
    output logic                               blast_active,
    output logic [$clog2(NUM_ROW*NUM_COL)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               wr_en,
    output logic [$clog2(NUM_ROW*NUM_COL)-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               done
);

    localparam int RW    = $clog2(NUM_ROW);
    localparam int CW    = $clog2(NUM_COL);
    localparam int AW    = $clog2(NUM_ROW*NUM_COL);
    localparam int TMAX  = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int CNT_W = $clog2(TMAX+1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CNT_W-1:0] fuse_q, fuse_d, hold_q, hold_d;
    logic            eval_q, eval_d;
    logic            wr_en_q, wr_en_d, ack_q, ack_d, done_q, done_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic            w_start, w_adv, w_next, pass_end;
    logic            w_in_bounds, w_last_k, w_last_dir, w_do_write, w_cont;
    logic [AW-1:0]   w_addr, ctr_addr, req_addr;
    logic [DATA_WIDTH-1:0] w_wr_val;
    mode_e           mode;

    assign ctr_addr = AW'(row_q) * AW'(NUM_COL) + AW'(col_q);
    assign req_addr = AW'(place_row) * AW'(NUM_COL) + AW'(place_col);
    assign mode     = (state_q == CLEAR_WALK) ? M_CLEAR : M_BLAST;

    tile_walker #(
        .NUM_ROW   (NUM_ROW),
        .NUM_COL   (NUM_COL),
        .DATA_WIDTH(DATA_WIDTH),
        .RANGE     (RANGE)
    ) u_walker (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .adv      (w_adv),
        .next_dir (w_next),
        .mode     (mode),
        .row      (row_q),
        .col      (col_q),
        .rd_data  (rd_data),
        .addr     (w_addr),
        .in_bounds(w_in_bounds),
        .last_k   (w_last_k),
        .last_dir (w_last_dir),
        .do_write (w_do_write),
        .wr_val   (w_wr_val),
        .cont     (w_cont)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            fuse_q    <= '0;
            hold_q    <= '0;
            eval_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            fuse_q    <= fuse_d;
            hold_q    <= hold_d;
            eval_q    <= eval_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        fuse_d    = fuse_q;
        hold_d    = hold_q;
        eval_d    = eval_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        rd_addr   = '0;
        w_start   = 1'b0;
        w_adv     = 1'b0;
        w_next    = 1'b0;
        pass_end  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (place_req) begin
                    row_d   = place_row;
                    col_d   = place_col;
                    rd_addr = req_addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rd_data == DATA_WIDTH'(T_EMPTY)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ctr_addr;
                    wr_data_d = DATA_WIDTH'(T_BOMB);
                    ack_d     = 1'b1;
                    fuse_d    = CNT_W'(FUSE_TICKS);
                    state_d   = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (tick) begin
                    if (fuse_q <= CNT_W'(1)) begin
                        fuse_d    = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ctr_addr;
                        wr_data_d = DATA_WIDTH'(T_EXPLOSION);
                        w_start   = 1'b1;
                        eval_d    = 1'b0;
                        state_d   = BLAST_WALK;
                    end else begin
                        fuse_d = fuse_q - CNT_W'(1);
                    end
                end
            end
            BLAST_WALK, CLEAR_WALK: begin
                // eval_q=0 issues the read, eval_q=1 consumes rd_data
                if (!eval_q) begin
                    if (w_in_bounds) begin
                        rd_addr = w_addr;
                        eval_d  = 1'b1;
                    end else if (w_last_dir) begin
                        pass_end = 1'b1;
                    end else begin
                        w_next = 1'b1;
                    end
                end else begin
                    eval_d = 1'b0;
                    if (w_do_write) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = w_addr;
                        wr_data_d = w_wr_val;
                    end
                    if (w_cont && !w_last_k) begin
                        w_adv = 1'b1;
                    end else if (w_last_dir) begin
                        pass_end = 1'b1;
                    end else begin
                        w_next = 1'b1;
                    end
                end
                if (pass_end) begin
                    if (state_q == BLAST_WALK) begin
                        hold_d  = CNT_W'(BLAST_TICKS);
                        state_d = BLAST_HOLD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            BLAST_HOLD: begin
                if (tick) begin
                    if (hold_q <= CNT_W'(1)) begin
                        hold_d    = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ctr_addr;
                        wr_data_d = DATA_WIDTH'(T_EMPTY);
                        w_start   = 1'b1;
                        eval_d    = 1'b0;
                        state_d   = CLEAR_WALK;
                    end else begin
                        hold_d = hold_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign place_ack    = ack_q;
    assign done         = done_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = (state_q != IDLE);
    assign blast_active = (state_q == BLAST_WALK) || (state_q == BLAST_HOLD) ||
                          (state_q == CLEAR_WALK);

endmodule

// File: tb/tb_bomb_ctrl.sv
// Scoreboard bench for bomb_ctrl: a behavioural map memory, expected
// ack/write/done events queued by stimulus and popped by a monitor.
module tb_bomb_ctrl;
    import bomb_pkg::*;

    localparam int NR = 11;
    localparam int NC = 19;
    localparam int DW = 4;
    localparam int RW = $clog2(NR);
    localparam int CW = $clog2(NC);
    localparam int AW = $clog2(NR*NC);
    localparam int K_ACK  = 0;
    localparam int K_W    = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic          clk, rst_n, tick, place_req;
    logic [RW-1:0] place_row;
    logic [CW-1:0] place_col;
    logic          place_ack, busy, blast_active, wr_en, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, wr_data;

    logic          map_clr, poke_en, mon_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_val;
    logic [DW-1:0] map_m [NR*NC];

    ev_t q[$];
    int  lst[$];
    int  n_chk = 0;
    int  n_fail = 0;

    bomb_ctrl #(
        .NUM_ROW    (NR),
        .NUM_COL    (NC),
        .DATA_WIDTH (DW),
        .FUSE_TICKS (3),
        .BLAST_TICKS(2),
        .RANGE      (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .place_req   (place_req),
        .place_row   (place_row),
        .place_col   (place_col),
        .place_ack   (place_ack),
        .busy        (busy),
        .blast_active(blast_active),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= map_m[rd_addr];
        if (map_clr) begin
            foreach (map_m[i]) map_m[i] <= '0;
        end else if (poke_en) begin
            map_m[poke_addr] <= poke_val;
        end else if (wr_en) begin
            map_m[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input int a, input int d);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0d, expected none",
                     kind, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr != a || e.data != d) begin
                n_fail++;
                $display("FAIL event: got kind %0d addr %0d data %0d, expected kind %0d addr %0d data %0d",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (place_ack) pop_cmp(K_ACK, 0, 0);
            if (wr_en) pop_cmp(K_W, int'(wr_addr), int'(wr_data));
            if (done) begin
                pop_cmp(K_DONE, 0, 0);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic push(input int kind, input int a, input int d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic push_list(input int d);
        foreach (lst[i]) push(K_W, lst[i], d);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_drained"}, q.size(), 0);
    endtask

    task automatic place(input int r, input int c, input logic tk);
        @(posedge clk);
        #1 place_req = 1'b1;
        place_row = RW'(r);
        place_col = CW'(c);
        tick = tk;
        @(posedge clk);
        #1 place_req = 1'b0;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    endtask

    task automatic poke(input int a, input int v);
        @(posedge clk);
        #1 poke_en = 1'b1;
        poke_addr = AW'(a);
        poke_val = DW'(v);
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic clear_map();
        @(posedge clk);
        #1 map_clr = 1'b1;
        @(posedge clk);
        #1 map_clr = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick = 1'b0;
        place_req = 1'b0;
        place_row = '0;
        place_col = '0;
        poke_en = 1'b0;
        poke_addr = '0;
        poke_val = '0;
        mon_en = 1'b1;
        map_clr = 1'b1;
        idle_wait(2);
        map_clr = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_ack", int'(place_ack), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        rst_n = 1'b1;
        idle_wait(2);

        // empty map, center (5,9)
        push(K_ACK, 0, 0);
        push(K_W, 104, T_BOMB);
        place(5, 9, 1'b0);
        @(posedge clk);
        #1 chk("ack_latency", int'(place_ack), 1);
        drain("c1_place");
        chk("c1_armed_busy", int'(busy), 1);
        chk("c1_armed_blast", int'(blast_active), 0);
        lst = '{104, 85, 66, 123, 142, 103, 102, 105, 106};
        push_list(T_EXPLOSION);
        ticks(3);
        drain("c1_blast");
        chk("c1_hold_blast", int'(blast_active), 1);
        push_list(T_EMPTY);
        push(K_DONE, 0, 0);
        ticks(2);
        drain("c1_clear");
        idle_wait(2);
        chk("c1_idle", int'(busy), 0);

        // wall above, brick below
        poke(85, T_WALL);
        poke(123, T_BRICK);
        push(K_ACK, 0, 0);
        push(K_W, 104, T_BOMB);
        place(5, 9, 1'b0);
        drain("c2_place");
        lst = '{104, 123, 103, 102, 105, 106};
        push_list(T_EXPLOSION);
        ticks(3);
        drain("c2_blast");
        push_list(T_EMPTY);
        push(K_DONE, 0, 0);
        ticks(2);
        drain("c2_clear");
        idle_wait(2);
        chk("c2_wall_kept", int'(map_m[85]), T_WALL);
        poke(85, T_EMPTY);

        // corner (0,0), tick coinciding with the request is ignored
        push(K_ACK, 0, 0);
        push(K_W, 0, T_BOMB);
        place(0, 0, 1'b1);
        drain("c3_place");
        ticks(2);
        idle_wait(10);
        chk("c3_fuse_busy", int'(busy), 1);
        chk("c3_fuse_blast", int'(blast_active), 0);
        lst = '{0, 19, 38, 1, 2};
        push_list(T_EXPLOSION);
        ticks(1);
        drain("c3_blast");
        push_list(T_EMPTY);
        push(K_DONE, 0, 0);
        ticks(2);
        drain("c3_clear");
        idle_wait(2);

        // request while armed is dropped
        push(K_ACK, 0, 0);
        push(K_W, 104, T_BOMB);
        place(5, 9, 1'b0);
        drain("c4_place");
        place(2, 2, 1'b0);
        idle_wait(5);
        chk("c4_still_busy", int'(busy), 1);
        chk("c4_still_armed", int'(blast_active), 0);
        lst = '{104, 85, 66, 123, 142, 103, 102, 105, 106};
        push_list(T_EXPLOSION);
        ticks(3);
        drain("c4_blast");
        push_list(T_EMPTY);
        push(K_DONE, 0, 0);
        ticks(2);
        drain("c4_clear");
        idle_wait(2);

        // placement on a wall is refused
        poke(40, T_WALL);
        place(2, 2, 1'b0);
        idle_wait(5);
        chk("c4_wall_idle", int'(busy), 0);
        chk("c4_wall_tile", int'(map_m[40]), T_WALL);
        poke(40, T_EMPTY);

        // reset during the blast walk
        push(K_ACK, 0, 0);
        push(K_W, 104, T_BOMB);
        place(5, 9, 1'b0);
        drain("c5_place");
        mon_en = 1'b0;
        ticks(3);
        idle_wait(2);
        chk("c5_walking", int'(blast_active), 1);
        rst_n = 1'b0;
        #1;
        chk("c5_rst_busy", int'(busy), 0);
        chk("c5_rst_blast", int'(blast_active), 0);
        chk("c5_rst_wr_en", int'(wr_en), 0);
        chk("c5_rst_wr_addr", int'(wr_addr), 0);
        chk("c5_rst_wr_data", int'(wr_data), 0);
        chk("c5_rst_done", int'(done), 0);
        chk("c5_rst_rd_addr", int'(rd_addr), 0);
        q.delete();
        idle_wait(2);
        rst_n = 1'b1;
        clear_map();
        mon_en = 1'b1;
        push(K_ACK, 0, 0);
        push(K_W, 60, T_BOMB);
        place(3, 3, 1'b0);
        drain("c5_place2");
        lst = '{60, 41, 22, 79, 98, 59, 58, 61, 62};
        push_list(T_EXPLOSION);
        ticks(3);
        drain("c5_blast");
        push_list(T_EMPTY);
        push(K_DONE, 0, 0);
        ticks(2);
        drain("c5_clear");
        idle_wait(5);
        chk("final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bomb_ctrl.md
Name: bomb_ctrl

Overview:
- Write-side client of map_mem. Accepts a bomb placement on a map tile and writes BOMB into the tile.
- Counts down a fuse in frame ticks, then walks the blast cross and writes EXPLOSION tiles. Walls stop the blast; a brick is destroyed and stops its arm.
- Holds the blast for a fixed time, then clears the blast tiles back to EMPTY.
- Sits beside player_controller. Drives map_mem wr_* and owns a dedicated synchronous read port into the same map.

Parameters:
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- DATA_WIDTH, 4, tile state width
- FUSE_TICKS, 120, ticks from placement to detonation (≥1)
- BLAST_TICKS, 30, ticks the explosion stays on the map (≥1)
- RANGE, 2, maximum blast reach in tiles per direction (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame pulse
- place_req  in  1  request a bomb at place_row/place_col
- place_row  in  $clog2(NUM_ROW)  target row
- place_col  in  $clog2(NUM_COL)  target column
- place_ack  out  1  one-cycle pulse: placement accepted
- busy  out  1  high in every state except IDLE
- blast_active  out  1  high in BLAST_WALK, BLAST_HOLD and CLEAR_WALK
- rd_addr  out  $clog2(NUM_ROW*NUM_COL)  map read address; rd_data is valid 1 cycle later
- rd_data  in  DATA_WIDTH  map read data
- wr_en  out  1  map write strobe
- wr_addr  out  $clog2(NUM_ROW*NUM_COL)  map write address
- wr_data  out  DATA_WIDTH  map write data
- done  out  1  one-cycle pulse when the clear pass finishes

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0; all counters and latches are 0.
  - Reset mid-operation abandons any map restore. Tiles already written stay as written.
- Address rule: addr = row*NUM_COL + col, computed at full address width.
- Read latency: the state that drives rd_addr is always followed by an EVAL cycle that consumes rd_data.
- IDLE:
  - When place_req=1, latch row and col and drive rd_addr to the target tile. Go to CHECK.
  - When place_req=0, remain in IDLE.
- CHECK (rd_data valid):
  - If rd_data==T_EMPTY: wr_en=1, wr_data=T_BOMB, place_ack=1, fuse=FUSE_TICKS, go to ARMED.
  - Otherwise return to IDLE with no ack.
- ARMED: decrement fuse on each tick. When fuse hits 0 on a tick:
  - Write T_EXPLOSION at the center.
  - Set dir=UP and k=1.
  - Go to BLAST_WALK.
- BLAST_WALK, per direction in the order UP, DOWN, LEFT, RIGHT, for k = 1..RANGE:
  - Bounds: if the step would leave the map (row 0 going up, row NUM_ROW-1 going down, col 0 going left, col NUM_COL-1 going right), end this direction with no read.
  - Otherwise drive rd_addr, then evaluate on the next cycle:
    - T_WALL: end the direction, no write.
    - T_BRICK: write T_EXPLOSION, end the direction.
    - T_EMPTY: write T_EXPLOSION, k++.
    - Any other value: end the direction, no write.
  - A direction also ends after k=RANGE.
  - After RIGHT ends, load hold=BLAST_TICKS and go to BLAST_HOLD.
- BLAST_HOLD: decrement hold on each tick. At 0, write T_EMPTY at the center and go to CLEAR_WALK.
- CLEAR_WALK:
  - Same walk order and bounds as BLAST_WALK.
  - If the read returns T_EXPLOSION, write T_EMPTY and continue; any other value ends the direction.
  - After RIGHT ends: done=1 for one cycle, go to IDLE.
- At most one wr_en per cycle. wr_* and the ack/done pulses are registered.
- place_req while busy=1 is ignored; no ack and no queueing.
- tick coinciding with place_req in IDLE: tick is ignored (no fuse is running yet).
- Fuse and hold counters are sized $clog2(max(FUSE_TICKS, BLAST_TICKS)+1) and never wrap.

Decomposition:
- Package bomb_pkg:
  - Tile encodings: T_EMPTY=0, T_WALL=1, T_BRICK=2, T_BOMB=3, T_EXPLOSION=4.
  - dir_e enum: UP, DOWN, LEFT, RIGHT.
  - state_e enum: IDLE, CHECK, ARMED, BLAST_WALK, BLAST_HOLD, CLEAR_WALK.
  - The same tile encodings are used by drawcon and the map init files.
- Sub-module tile_walker:
  - Owns dir and k, the bounds check, and next-address generation.
  - Reused by both walk passes via a mode input: blast or clear.

Test Plan:
- Empty map, place (5,9), FUSE_TICKS=3 → ack 2 cycles after req; writes BOMB@104; after 3 ticks EXPLOSION@104,85,66,123,142,103,102,105,106.
- WALL@(4,9) and BRICK@(6,9) → up arm writes nothing; down arm writes only @123 (brick destroyed); left/right reach 2 tiles.
- Place at (0,0) → up and left arms issue no reads; down writes @19,38; right writes @1,2.
- After BLAST_TICKS ticks → all 9 tiles from the first case rewritten EMPTY; done pulses once; busy drops the same cycle.
- place_req while ARMED; place on a WALL tile → no ack, no write, state unchanged or back to IDLE respectively.
- rst_n low during BLAST_WALK → outputs 0 immediately; after release, place works normally.
